// File: rtl/seg7_pkg.sv
// Shared constants and scan-state encoding for the 7-segment scan controller.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg7_slot_timer.sv
// Per-digit slot counter: strobes end of blanking and end of slot; 0-cycle strobe latency.
// i_clr holds the count at 0 so the first slot after a (re)start is full length.
module seg7_slot_timer #(
    parameter int DIV       = 1000,
    parameter int BLANK_CYC = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_blank_end,
    output logic o_slot_end
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] r_cnt;

    assign o_blank_end = (r_cnt == CW'(BLANK_CYC - 1));
    assign o_slot_end  = (r_cnt == CW'(DIV - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_slot_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-seg scan with one shared external decoder; segment/anode pads registered.
// Frames are double-buffered: a new frame waits in the shadow until a frame boundary (load_ready low).
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int DIV       = 1000,
    parameter int BLANK_CYC = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_load_valid,
    output logic                  o_load_ready,
    input  logic [4*DIGITS-1:0]   i_load_bcd,
    input  logic [DIGITS-1:0]     i_load_dp,
    output logic [3:0]            o_dec_bcd,
    input  logic [6:0]            i_dec_seg,
    output logic [6:0]            o_seg_n,
    output logic                  o_dp_n,
    output logic [DIGITS-1:0]     o_an_n,
    output logic                  o_frame_done
);

    localparam int              IW       = $clog2(DIGITS);
    localparam logic [IW-1:0]   LAST_IDX = IW'(DIGITS - 1);

    scan_state_t          r_state;
    scan_state_t          w_state_nxt;
    logic [IW-1:0]        r_idx;
    logic [IW-1:0]        w_idx_nxt;
    logic [4*DIGITS-1:0]  r_act_bcd;
    logic [DIGITS-1:0]    r_act_dp;
    logic [4*DIGITS-1:0]  r_shd_bcd;
    logic [DIGITS-1:0]    r_shd_dp;
    logic                 r_pending;
    logic [6:0]           r_seg_n;
    logic                 r_dp_n;
    logic [DIGITS-1:0]    r_an_n;
    logic                 w_tmr_clr;
    logic                 w_blank_end;
    logic                 w_slot_end;
    logic                 w_frame_done;
    logic                 w_commit_pt;
    logic                 w_xfer;
    logic                 w_show_nxt;
    logic [DIGITS-1:0]    w_an_sel;

    assign w_tmr_clr = (r_state == IDLE) || !i_enable;

    seg7_slot_timer #(
        .DIV       (DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_slot_timer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clr       (w_tmr_clr),
        .o_blank_end (w_blank_end),
        .o_slot_end  (w_slot_end)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (!i_enable) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = BLANK;
                    w_idx_nxt   = '0;
                end
                BLANK: begin
                    if (w_blank_end) w_state_nxt = SHOW;
                end
                SHOW: begin
                    if (w_slot_end) begin
                        w_state_nxt = BLANK;
                        w_idx_nxt   = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    assign w_frame_done = i_enable && (r_state == SHOW) && w_slot_end && (r_idx == LAST_IDX);
    // Safe points to swap the active frame without tearing a scan in progress.
    assign w_commit_pt  = (r_state == IDLE) || w_frame_done;
    assign w_xfer       = i_load_valid && !r_pending;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_act_bcd <= '0;
            r_act_dp  <= '0;
            r_shd_bcd <= '0;
            r_shd_dp  <= '0;
            r_pending <= 1'b0;
        end else if (w_xfer && w_commit_pt) begin
            r_act_bcd <= i_load_bcd;
            r_act_dp  <= i_load_dp;
        end else if (w_xfer) begin
            r_shd_bcd <= i_load_bcd;
            r_shd_dp  <= i_load_dp;
            r_pending <= 1'b1;
        end else if (r_pending && w_commit_pt) begin
            r_act_bcd <= r_shd_bcd;
            r_act_dp  <= r_shd_dp;
            r_pending <= 1'b0;
        end
    end

    // Pads are loaded from the next state so they line up with r_state;
    // the decoder result sampled in the last blank cycle covers its latency.
    assign w_show_nxt = (w_state_nxt == SHOW);
    assign w_an_sel   = DIGITS'(1) << w_idx_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seg_n <= SEG_BLANK;
            r_dp_n  <= 1'b1;
            r_an_n  <= '1;
        end else begin
            r_seg_n <= w_show_nxt ? i_dec_seg : SEG_BLANK;
            r_dp_n  <= w_show_nxt ? ~r_act_dp[w_idx_nxt] : 1'b1;
            r_an_n  <= w_show_nxt ? ~w_an_sel : '1;
        end
    end

    assign o_dec_bcd    = (r_state == IDLE) ? 4'd0 : r_act_bcd[4*r_idx +: 4];
    assign o_seg_n      = r_seg_n;
    assign o_dp_n       = r_dp_n;
    assign o_an_n       = r_an_n;
    assign o_frame_done = w_frame_done;
    assign o_load_ready = !r_pending;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with an external decoder model and a per-slot scoreboard.
module tb_seg7_scan_ctrl;

    localparam int DIGITS    = 4;
    localparam int DIV       = 8;
    localparam int BLANK_CYC = 2;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } sb_t;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_bcd;
    logic [3:0]  load_dp;
    logic [3:0]  dec_bcd;
    logic [6:0]  dec_seg;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_done;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    sb_t         sb_q[$];
    logic [15:0] exp_cur_bcd, exp_next_bcd;
    logic [3:0]  exp_cur_dp, exp_next_dp;
    logic [3:0]  prev_an;

    seg7_scan_ctrl #(
        .DIGITS    (DIGITS),
        .DIV       (DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (enable),
        .i_load_valid (load_valid),
        .o_load_ready (load_ready),
        .i_load_bcd   (load_bcd),
        .i_load_dp    (load_dp),
        .o_dec_bcd    (dec_bcd),
        .i_dec_seg    (dec_seg),
        .o_seg_n      (seg_n),
        .o_dp_n       (dp_n),
        .o_an_n       (an_n),
        .o_frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    return ~7'h3F;
            4'd1:    return ~7'h06;
            4'd2:    return ~7'h5B;
            4'd3:    return ~7'h4F;
            4'd4:    return ~7'h66;
            4'd5:    return ~7'h6D;
            4'd6:    return ~7'h7D;
            4'd7:    return ~7'h07;
            4'd8:    return ~7'h7F;
            4'd9:    return ~7'h6F;
            default: return 7'h7F;
        endcase
    endfunction

    assign dec_seg = dec7(dec_bcd);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_frame(input logic [15:0] b, input logic [3:0] dp);
        sb_t        e;
        logic [3:0] a;
        for (int k = 0; k < DIGITS; k++) begin
            a     = 4'b0001 << k;
            e.an  = ~a;
            e.seg = dec7(b[k*4 +: 4]);
            e.dp  = ~dp[k];
            sb_q.push_back(e);
        end
    endfunction

    // One cycle per iteration; cyc counts from the cycle after enable was raised.
    task automatic run_cycles(input int n);
        int         slot, pos;
        logic [3:0] a, e_an, d;
        for (int i = 0; i < n; i++) begin
            cyc++;
            if ((cyc - 1) % (DIV * DIGITS) == 0) begin
                exp_cur_bcd = exp_next_bcd;
                exp_cur_dp  = exp_next_dp;
                push_frame(exp_cur_bcd, exp_cur_dp);
            end
            @(posedge clk);
            @(negedge clk);
            slot = ((cyc - 1) / DIV) % DIGITS;
            pos  = (cyc - 1) % DIV;
            a    = 4'b0001 << slot;
            e_an = (pos < BLANK_CYC) ? 4'hF : ~a;
            d    = exp_cur_bcd[slot*4 +: 4];
            check("an_n", an_n, e_an);
            check("dec_bcd", dec_bcd, d);
            check("frame_done", frame_done, (slot == DIGITS - 1) && (pos == DIV - 1));
        end
    endtask

    initial prev_an = 4'hF;

    always @(negedge clk) begin
        sb_t e;
        if (rst_n) begin
            check("an_onehot", (an_n == 4'hF) || $onehot(~an_n), 1);
            if (an_n != 4'hF && prev_an == 4'hF) begin
                check("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("slot_an_n", an_n, e.an);
                    check("slot_seg_n", seg_n, e.seg);
                    check("slot_dp_n", dp_n, e.dp);
                end
            end
        end
        prev_an = an_n;
    end

    initial begin
        rst_n        = 1'b0;
        enable       = 1'b0;
        load_valid   = 1'b0;
        load_bcd     = '0;
        load_dp      = '0;
        exp_next_bcd = '0;
        exp_next_dp  = '0;
        exp_cur_bcd  = '0;
        exp_cur_dp   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_seg_n", seg_n, 7'h7F);
        check("rst_dp_n", dp_n, 1'b1);
        check("rst_an_n", an_n, 4'hF);
        check("rst_load_ready", load_ready, 1'b1);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_dec_bcd", dec_bcd, 4'd0);
        rst_n = 1'b1;

        // Disabled: dark and ready throughout.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("idle_seg_n", seg_n, 7'h7F);
            check("idle_an_n", an_n, 4'hF);
            check("idle_load_ready", load_ready, 1'b1);
        end

        // Load while idle goes straight to the active frame.
        load_valid   = 1'b1;
        load_bcd     = 16'h1234;
        load_dp      = 4'b0000;
        exp_next_bcd = 16'h1234;
        exp_next_dp  = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        check("idle_load_bypass_ready", load_ready, 1'b1);
        enable = 1'b1;
        cyc    = 0;
        run_cycles(41);

        // Mid-frame load during digit 1 of the second frame.
        check("pre_load_ready", load_ready, 1'b1);
        load_valid   = 1'b1;
        load_bcd     = 16'h9876;
        load_dp      = 4'b0000;
        exp_next_bcd = 16'h9876;
        exp_next_dp  = 4'b0000;
        run_cycles(1);
        load_valid = 1'b0;
        check("pending_load_ready", load_ready, 1'b0);
        run_cycles(22);
        check("frame_end_load_ready", load_ready, 1'b0);
        run_cycles(1);
        check("commit_load_ready", load_ready, 1'b1);
        run_cycles(31);

        // Load offered in the frame_done cycle: bypasses the shadow.
        check("fd_cycle_frame_done", frame_done, 1'b1);
        load_valid   = 1'b1;
        load_bcd     = 16'h3A05;
        load_dp      = 4'b0100;
        exp_next_bcd = 16'h3A05;
        exp_next_dp  = 4'b0100;
        run_cycles(1);
        load_valid = 1'b0;
        check("fd_bypass_ready", load_ready, 1'b1);
        run_cycles(19);

        // Drop enable during digit 2 SHOW.
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("dis_an_n", an_n, 4'hF);
        check("dis_seg_n", seg_n, 7'h7F);
        check("dis_dp_n", dp_n, 1'b1);
        check("dis_frame_done", frame_done, 1'b0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("dis_idle_an_n", an_n, 4'hF);
        end
        sb_q.delete();
        enable = 1'b1;
        cyc    = 0;
        run_cycles(35);

        // Pending frame then async reset mid-SHOW.
        load_valid = 1'b1;
        load_bcd   = 16'h5555;
        load_dp    = 4'b1111;
        run_cycles(1);
        load_valid = 1'b0;
        check("pre_rst_pending_ready", load_ready, 1'b0);
        check("pre_rst_an_n", an_n, 4'hE);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_an_n", an_n, 4'hF);
        check("async_rst_seg_n", seg_n, 7'h7F);
        check("async_rst_dp_n", dp_n, 1'b1);
        check("async_rst_ready", load_ready, 1'b1);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sb_q.delete();
        exp_next_bcd = 16'h0000;
        exp_next_dp  = 4'b0000;
        enable = 1'b1;
        cyc    = 0;
        run_cycles(32);
        check("post_rst_ready", load_ready, 1'b1);
        check("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
